// File: rtl/dmem_load_sequencer_pkg.sv
// dmem_load_sequencer_pkg: shared state encoding and memory depth for the load sequencer
package dmem_load_sequencer_pkg;
  typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_FLUSH, LD_DONE} load_state_t;
  localparam int DMEM_DEPTH = 1024;
endpackage

// File: rtl/dmem_load_sequencer.sv
// dmem_load_sequencer: streams a word image into data SRAM, checksums it and raises START when committed
module dmem_load_sequencer
  import dmem_load_sequencer_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW = $clog2(DEPTH),
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LOAD_REQ,
  input  logic [AW-1:0] LOAD_BASE,
  input  logic [AW:0]   LOAD_LEN,
  input  logic          ABORT,
  input  logic          IN_VALID,
  input  logic [DW-1:0] IN_DATA,
  output logic          IN_READY,
  output logic          TB_LOAD_DATA_CTRL,
  output logic [AW-1:0] TB_LOAD_DATA_ADDR,
  output logic [DW-1:0] TB_LOAD_DATA_DATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic          START,
  output logic [DW-1:0] CHECKSUM
);
  localparam logic [AW:0] depth_w = (AW+1)'(DEPTH);
  load_state_t state, state_next;
  logic [AW-1:0] base, idx;
  logic [AW:0] remaining;
  logic idle_or_done, live, range_bad, req_ok, req_bad, kill, beat;
  assign idle_or_done = state == LD_IDLE || state == LD_DONE;
  assign live = state == LD_LOAD || state == LD_FLUSH;
  assign range_bad = ({1'b0, LOAD_BASE} + LOAD_LEN) > depth_w;
  assign req_ok = LOAD_REQ & idle_or_done & ~range_bad;
  assign req_bad = LOAD_REQ & idle_or_done & range_bad;
  assign kill = ABORT & live;
  assign IN_READY = state == LD_LOAD && remaining != '0 && !ABORT;
  assign beat = IN_VALID & IN_READY;
  assign BUSY = live;
  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= LD_IDLE;
    else state <= state_next;
  end
  // next state: an accepted request outranks abort, which in DONE is meaningless anyway
  always_comb begin
    state_next = state;
    if (req_ok) state_next = LOAD_LEN == '0 ? LD_FLUSH : LD_LOAD;
    else if (kill) state_next = LD_IDLE;
    else if (state == LD_LOAD && beat && remaining == (AW+1)'(1)) state_next = LD_FLUSH;
    else if (state == LD_FLUSH) state_next = LD_DONE;
  end
  // counters, registered write port, status pulses and checksum
  always_ff @(posedge CLK) begin
    if (RST) begin
      base <= '0;
      idx <= '0;
      remaining <= '0;
      TB_LOAD_DATA_CTRL <= 1'b0;
      TB_LOAD_DATA_ADDR <= '0;
      TB_LOAD_DATA_DATA <= '0;
      DONE <= 1'b0;
      ERR <= 1'b0;
      START <= 1'b0;
      CHECKSUM <= '0;
    end else begin
      TB_LOAD_DATA_CTRL <= beat;
      DONE <= state == LD_FLUSH && !ABORT;
      ERR <= req_bad | kill;
      if (beat) begin
        TB_LOAD_DATA_ADDR <= base + idx;
        TB_LOAD_DATA_DATA <= IN_DATA;
        idx <= idx + 1'b1;
        remaining <= remaining - 1'b1;
        CHECKSUM <= CHECKSUM + IN_DATA;
      end
      if (req_ok) begin
        base <= LOAD_BASE;
        idx <= '0;
        remaining <= LOAD_LEN;
        CHECKSUM <= '0;
      end
      if (req_ok || kill) START <= 1'b0;
      else if (state == LD_FLUSH) START <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dmem_load_sequencer.sv
// tb_dmem_load_sequencer: directed checks of load, range reject, gaps, abort, wrap and empty load
module tb_dmem_load_sequencer;
  logic CLK = 1'b0;
  logic RST, LOAD_REQ, ABORT, IN_VALID;
  logic [9:0] LOAD_BASE;
  logic [10:0] LOAD_LEN;
  logic [31:0] IN_DATA;
  logic IN_READY, CTRL, BUSY, DONE, ERR, START;
  logic [9:0] ADDR;
  logic [31:0] DATA, CHECKSUM;
  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, clash = 0, last_ctrl = 0, start_rise = 0;
  logic start_q = 1'b0;
  logic [9:0] wa[$];
  logic [31:0] wd[$];
  int wc[$];
  logic [31:0] tx[$];
  int e0;

  dmem_load_sequencer dut (
    .CLK(CLK), .RST(RST), .LOAD_REQ(LOAD_REQ), .LOAD_BASE(LOAD_BASE), .LOAD_LEN(LOAD_LEN),
    .ABORT(ABORT), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .TB_LOAD_DATA_CTRL(CTRL), .TB_LOAD_DATA_ADDR(ADDR), .TB_LOAD_DATA_DATA(DATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .START(START), .CHECKSUM(CHECKSUM)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    cyc++;
    if (CTRL) begin
      wa.push_back(ADDR);
      wd.push_back(DATA);
      wc.push_back(cyc);
      last_ctrl = cyc;
    end
    if (DONE) done_cnt++;
    if (ERR) err_cnt++;
    if (START && CTRL) clash++;
    if (START && !start_q) start_rise = cyc;
    start_q = START;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic req(input logic [9:0] b, input logic [10:0] l);
    @(negedge CLK);
    LOAD_REQ = 1'b1;
    LOAD_BASE = b;
    LOAD_LEN = l;
    @(negedge CLK);
    LOAD_REQ = 1'b0;
  endtask

  task automatic send(input bit gap);
    logic rdy;
    int n;
    for (int i = 0; i < tx.size(); i++) begin
      if (gap && i > 0) begin
        IN_VALID = 1'b0;
        @(negedge CLK);
      end
      IN_VALID = 1'b1;
      IN_DATA = tx[i];
      n = 0;
      do begin
        rdy = IN_READY;
        @(negedge CLK);
        n++;
      end while (!rdy && n < 20);
      chk("beat_accepted", 32'(rdy), 32'd1);
    end
    IN_VALID = 1'b0;
  endtask

  task automatic wait_done();
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 30) begin
      @(negedge CLK);
      n++;
    end
    chk("done_pulse", 32'(done_cnt - d0), 32'd1);
    @(negedge CLK);
  endtask

  task automatic clear();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  initial begin
    RST = 1'b1; LOAD_REQ = 1'b0; ABORT = 1'b0; IN_VALID = 1'b0;
    LOAD_BASE = '0; LOAD_LEN = '0; IN_DATA = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    req(10'h010, 11'd4);
    tx = '{32'hA};
    send(1'b0);
    chk("busy_mid_load", 32'(BUSY), 32'd1);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_ctrl", 32'(CTRL), 32'd0);
    chk("rst_addr", 32'(ADDR), 32'd0);
    chk("rst_data", DATA, 32'd0);
    chk("rst_sum", CHECKSUM, 32'd0);
    chk("rst_flags", 32'({BUSY, DONE, ERR, START, IN_READY}), 32'd0);
    RST = 1'b0;
    clear();

    req(10'h010, 11'd4);
    tx = '{32'd1, 32'd2, 32'd3, 32'd4};
    send(1'b0);
    wait_done();
    chk("t1_nwrites", 32'(wa.size()), 32'd4);
    chk("t1_addr0", 32'(wa[0]), 32'h010);
    chk("t1_addr3", 32'(wa[3]), 32'h013);
    chk("t1_data3", wd[3], 32'd4);
    chk("t1_b2b", 32'(wc[3] - wc[0]), 32'd3);
    chk("t1_sum", CHECKSUM, 32'd10);
    chk("t1_start", 32'(START), 32'd1);
    chk("t1_start_lag", 32'(start_rise - last_ctrl), 32'd1);
    chk("t1_clash", 32'(clash), 32'd0);

    clear();
    e0 = err_cnt;
    req(10'h3FE, 11'd3);
    repeat (3) @(negedge CLK);
    chk("t2_err", 32'(err_cnt - e0), 32'd1);
    chk("t2_nowrite", 32'(wa.size()), 32'd0);
    chk("t2_start_kept", 32'(START), 32'd1);
    req(10'h001, 11'd1024);
    repeat (3) @(negedge CLK);
    chk("t2_err_full", 32'(err_cnt - e0), 32'd2);
    req(10'h3FE, 11'd2);
    tx = '{32'd5, 32'd6};
    send(1'b0);
    wait_done();
    chk("t2_nwrites", 32'(wa.size()), 32'd2);
    chk("t2_last_addr", 32'(wa[1]), 32'h3FF);
    chk("t2_sum", CHECKSUM, 32'd11);

    clear();
    req(10'h100, 11'd5);
    tx = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14};
    send(1'b1);
    wait_done();
    chk("t3_nwrites", 32'(wa.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t3_addr", 32'(wa[i]), 32'h100 + 32'(i));
      chk("t3_data", wd[i], 32'd10 + 32'(i));
    end
    chk("t3_gaps", 32'(wc[4] - wc[0]), 32'd8);
    chk("t3_sum", CHECKSUM, 32'd60);

    clear();
    e0 = err_cnt;
    req(10'h200, 11'd6);
    tx = '{32'd7, 32'd8};
    send(1'b0);
    ABORT = 1'b1;
    IN_VALID = 1'b1;
    IN_DATA = 32'd99;
    #1;
    chk("t4_ready_abort", 32'(IN_READY), 32'd0);
    @(negedge CLK);
    ABORT = 1'b0;
    IN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    chk("t4_nwrites", 32'(wa.size()), 32'd2);
    chk("t4_err", 32'(err_cnt - e0), 32'd1);
    chk("t4_start", 32'(START), 32'd0);
    chk("t4_busy", 32'(BUSY), 32'd0);
    chk("t4_ready", 32'(IN_READY), 32'd0);
    chk("t4_sum", CHECKSUM, 32'd15);

    clear();
    req(10'h000, 11'd2);
    tx = '{32'hFFFF_FFFF, 32'h0000_0002};
    send(1'b0);
    wait_done();
    chk("t5_wrap_sum", CHECKSUM, 32'h0000_0001);
    chk("t5_nwrites", 32'(wa.size()), 32'd2);

    clear();
    req(10'h040, 11'd0);
    wait_done();
    chk("t6_sum", CHECKSUM, 32'd0);
    chk("t6_nwrites", 32'(wa.size()), 32'd0);
    chk("t6_start", 32'(START), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
